// File: rtl/full_adder_if.sv
// Operand/result bundle for one full-adder bit-slice.
// Master drives operands, slave returns sums.
interface full_adder_if;
    logic a;
    logic b;
    logic carry_in;
    logic in_valid;
    logic sum;
    logic carry_out;
    logic sum_q;
    logic carry_out_q;
    logic out_valid;

    modport master (
        output a, b, carry_in, in_valid,
        input  sum, carry_out, sum_q, carry_out_q, out_valid
    );

    modport slave (
        input  a, b, carry_in, in_valid,
        output sum, carry_out, sum_q, carry_out_q, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders,
// with an optional valid-qualified output register.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder #(
    parameter bit REGISTER_OUT = 1'b1
) (
    output logic sum,
    output logic carry_out,
    input  logic a,
    input  logic b,
    input  logic carry_in,
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic sum_q,
    output logic carry_out_q,
    output logic out_valid
);
    logic p;
    logic g1;
    logic g2;

    half_adder u_ha1 (
        .x (a),
        .y (b),
        .s (p),
        .c (g1)
    );

    half_adder u_ha2 (
        .x (p),
        .y (carry_in),
        .s (sum),
        .c (g2)
    );

    assign carry_out = g1 | g2;

    generate
        if (REGISTER_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q       <= 1'b0;
                    carry_out_q <= 1'b0;
                    out_valid   <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        sum_q       <= sum;
                        carry_out_q <= carry_out;
                    end
                end
            end
        end else begin : g_noreg
            assign sum_q       = 1'b0;
            assign carry_out_q = 1'b0;
            assign out_valid   = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: arithmetic model,
// random and directed stimulus, plus a 4-bit ripple chain.
module tb_full_adder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    full_adder_if fa ();

    full_adder dut (
        .sum         (fa.sum),
        .carry_out   (fa.carry_out),
        .a           (fa.a),
        .b           (fa.b),
        .carry_in    (fa.carry_in),
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (fa.in_valid),
        .sum_q       (fa.sum_q),
        .carry_out_q (fa.carry_out_q),
        .out_valid   (fa.out_valid)
    );

    logic [3:0] rx;
    logic [3:0] ry;
    logic [3:0] rs;
    logic [4:0] rc;
    logic [3:0] rsq;
    logic [3:0] rcq;
    logic [3:0] rov;

    for (genvar i = 0; i < 4; i++) begin : g_rip
        full_adder u_fa (
            .sum         (rs[i]),
            .carry_out   (rc[i+1]),
            .a           (rx[i]),
            .b           (ry[i]),
            .carry_in    (rc[i]),
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (1'b0),
            .sum_q       (rsq[i]),
            .carry_out_q (rcq[i]),
            .out_valid   (rov[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] expq[$];
    logic [1:0] last;

    task automatic chk(string name, logic [4:0] act,
                       logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [1:0] model(int x, int y,
                                         int z);
        int t;
        t = x + y + z;
        return t[1:0];
    endfunction

    // Monitor: pops the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            last = 2'b00;
            chk("reset_q",
                {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
                5'd0);
        end else if (fa.out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_out", 5'd1, 5'd0);
            end else begin
                last = expq.pop_front();
                chk("reg_out",
                    {3'b0, fa.carry_out_q, fa.sum_q},
                    {3'b0, last});
            end
        end else begin
            chk("hold", {3'b0, fa.carry_out_q, fa.sum_q},
                {3'b0, last});
        end
    end

    task automatic apply(logic [2:0] v);
        {fa.a, fa.b, fa.carry_in} = v;
        #1;
        chk("comb", {3'b0, fa.carry_out, fa.sum},
            {3'b0, model(v[2], v[1], v[0])});
    endtask

    task automatic cycle(logic [2:0] v, logic vld);
        fa.in_valid = vld;
        apply(v);
        if (vld)
            expq.push_back(model(v[2], v[1], v[0]));
        @(posedge clk);
        #1;
    endtask

    logic [2:0] dseq[5];
    logic [1:0] dexp[5];

    initial begin
        tests = 0;
        fails = 0;
        last  = 2'b00;
        rst_n = 1'b0;
        fa.a = 1'b0;
        fa.b = 1'b0;
        fa.carry_in = 1'b0;
        fa.in_valid = 1'b0;
        rx = 4'd0;
        ry = 4'd0;
        rc[0] = 1'b0;
        #3;
        chk("rst_state",
            {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
            5'd0);

        apply(3'b111);
        chk("rst_comb", {3'b0, fa.carry_out, fa.sum}, 5'd3);
        chk("rst_q111",
            {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
            5'd0);

        dseq = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b111};
        dexp = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
        foreach (dseq[i]) begin
            {fa.a, fa.b, fa.carry_in} = dseq[i];
            #1;
            chk("directed", {3'b0, fa.carry_out, fa.sum},
                {3'b0, dexp[i]});
            #19;
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            apply(v);
            if (v == 3'b011 || v == 3'b110)
                chk("exh_011_110",
                    {3'b0, fa.carry_out, fa.sum}, 5'd2);
            #9;
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(3'b000, 1'b0);

        cycle(3'b101, 1'b1);
        chk("cap_101",
            {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
            5'b00110);
        cycle(3'b001, 1'b0);
        chk("hold_001",
            {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
            5'b00010);

        for (int i = 0; i < 300; i++)
            cycle(3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));

        cycle(3'b111, 1'b1);
        cycle(3'b111, 1'b1);
        cycle(3'b111, 1'b1);
        #2;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("midrst",
            {2'b0, fa.out_valid, fa.carry_out_q, fa.sum_q},
            5'd0);
        chk("midrst_comb",
            {3'b0, fa.carry_out, fa.sum}, 5'd3);
        fa.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++)
            cycle(3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
        cycle(3'b000, 1'b0);
        cycle(3'b000, 1'b0);
        chk("queue_empty", 5'(expq.size()), 5'd0);

        rx = 4'b1011;
        ry = 4'b0110;
        rc[0] = 1'b0;
        #1;
        chk("ripple", {rc[4], rs}, 5'b10001);
        for (int i = 0; i < 20; i++) begin
            logic [4:0] t;
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            rc[0] = 1'($urandom_range(0, 1));
            #1;
            t = 5'(rx) + 5'(ry) + 5'(rc[0]);
            chk("ripple_rand", {rc[4], rs}, t);
        end

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end
endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder: sums operands `a`, `b` and `carry_in` into `sum` and `carry_out`. It is the bit-slice primitive that the 32-bit ripple-carry adder chains. `sum` and `carry_out` are purely combinational. A registered copy of the result, qualified by a valid flag, is provided on a single clock for pipelined users.

## Interface
- `REGISTER_OUT`, default 1: 1 = registered outputs `sum_q`/`carry_out_q`/`out_valid` are implemented; 0 = those outputs are tied to 0.
- `clk` input 1 — single clock; all registers update on the rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `sum` output 1 — combinational sum bit.
- `carry_out` output 1 — combinational carry out.
- `a` input 1 — operand A.
- `b` input 1 — operand B.
- `carry_in` input 1 — carry in from the lower bit-slice.
- `in_valid` input 1 — qualifies `a`/`b`/`carry_in` for the registered stage.
- `sum_q` output 1 — registered `sum`.
- `carry_out_q` output 1 — registered `carry_out`.
- `out_valid` output 1 — registered `in_valid`.
- Positional order of the first five ports is fixed: `sum, carry_out, a, b, carry_in`. The ports `clk, rst_n, in_valid, sum_q, carry_out_q, out_valid` follow in that order.

## Operation
- `sum = a ^ b ^ carry_in`.
- `carry_out = (a & b) | (carry_in & (a ^ b))`.
- Combinational core structure: two half adders plus an OR gate.
  - Half adder 1 takes `a, b` and produces `p = a^b` and `g1 = a&b`.
  - Half adder 2 takes `p, carry_in` and produces `sum` and `g2 = p&carry_in`.
  - `carry_out = g1 | g2`.
- The combinational outputs do not depend on `clk`, `rst_n` or `in_valid`. They are valid during reset.
- Arithmetic identity: `{carry_out,sum} = a + b + carry_in`, with a 2-bit result in the range 0..3.
- Registered stage (`REGISTER_OUT=1`):
  - On each rising `clk` edge with `rst_n=1`, `out_valid <= in_valid`.
  - If `in_valid=1`, then `sum_q <= sum` and `carry_out_q <= carry_out`.
  - If `in_valid=0`, `sum_q`/`carry_out_q` hold their previous values.
- Reset: while `rst_n=0`, `sum_q=0`, `carry_out_q=0` and `out_valid=0`, regardless of `clk`.
- X/Z on inputs propagates per standard Verilog gate semantics. No masking is applied.

## Timing
- Combinational path has zero cycles of latency. Outputs settle within one stimulus step after any input change (zero-delay gates in simulation).
- Registered path has 1 cycle of latency: inputs sampled at edge N appear on `sum_q`/`carry_out_q`/`out_valid` after edge N.
- Reset assertion (`rst_n` falling) clears the registered outputs immediately, with no clock required, including mid-stream.
- Reset deassertion is synchronised by the user. The first capture occurs at the first rising edge with `rst_n=1`.
- If `in_valid` and reset deassertion coincide at the same edge, the sample is captured only if `rst_n` was already high before that edge.
- There is no backpressure and no handshake beyond `in_valid`/`out_valid`.

## Test plan
- Apply the input sequence `a,b,carry_in` = 000, 001, 101, 100, 111, holding each for 20 time units. Required `sum,carry_out` = 0/0, 1/0, 0/1, 1/0, 1/1.
- Exhaustive: apply all 8 input combinations and check `{carry_out,sum} == a+b+carry_in`. Vectors 011 and 110 must give sum=0, carry_out=1.
- With `rst_n=0`, apply `a=1, b=1, carry_in=1`. Combinational outputs must be `sum=1, carry_out=1`, and `sum_q=carry_out_q=out_valid=0`.
- Release reset, then drive `in_valid=1` with 101 at one edge. After that edge, `sum_q=0`, `carry_out_q=1`, `out_valid=1`. At the next edge drive `in_valid=0` with 001: `sum_q`/`carry_out_q` hold 0/1 and `out_valid=0`.
- Stream 111 with `in_valid=1`, then pull `rst_n` low between clock edges. The registered outputs must drop to 0 immediately.
- Chain 4 instances as a ripple adder and add 4'b1011 + 4'b0110 with `carry_in=0`. The required result is 4'b0001 with the final carry_out=1.
